// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch path.
package if_pkg;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order queue of fetched {pc, instr} entries; head is read combinationally.
module fetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  fetch_entry_t                 din,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t    r_mem [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone says what is live.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= din;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, queues ROM words with their PCs and
// hands them to decode; redirects flush the queue and restart at the target.
module instr_fetch_ctrl
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fetch_en,
  output logic [31:0]                  rom_addr,
  input  logic [31:0]                  rom_data,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [31:0]                  instr_data,
  output logic [31:0]                  instr_pc,
  output logic [$clog2(DEPTH+1)-1:0]   q_count,
  output logic                         misalign_err
);

  localparam int            CW       = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]  r_fpc;
  logic         r_misalign;

  fetch_entry_t w_head;
  fetch_entry_t w_din;
  logic [CW-1:0] w_count;
  logic         w_valid;
  logic         w_pop;
  logic         w_push;

  // A redirect hides the head immediately so nothing stale is consumed.
  assign w_valid = (w_count != '0) && !redirect_valid;
  assign w_pop   = w_valid && instr_ready;
  assign w_push  = fetch_en && !redirect_valid && ((w_count < FULL_CNT) || w_pop);
  assign w_din   = {r_fpc, rom_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fpc      <= RESET_PC;
      r_misalign <= 1'b0;
    end else if (redirect_valid) begin
      r_fpc      <= {redirect_pc[31:2], 2'b00};
      r_misalign <= |redirect_pc[1:0];
    end else begin
      r_misalign <= 1'b0;
      if (w_push) r_fpc <= r_fpc + 32'(INSTR_BYTES);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .head  (w_head),
    .count (w_count)
  );

  assign rom_addr     = r_fpc;
  assign instr_valid  = w_valid;
  assign instr_data   = w_valid ? w_head.instr : NOP_INSTR;
  assign instr_pc     = w_valid ? w_head.pc    : 32'h0000_0000;
  assign q_count      = w_count;
  assign misalign_err = r_misalign;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: queue-based reference model checked every cycle
// plus directed scenarios with literal expectations.
module tb_instr_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic [2:0]  q_count;
  logic        misalign_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    if (a == 32'h0) return 32'h0020_8233;
    return {a[29:0], 2'b11} ^ 32'h1357_0000;
  endfunction

  assign rom_data = rom_f(rom_addr);

  instr_fetch_ctrl #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .q_count        (q_count),
    .misalign_err   (misalign_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {pc, instr} plus the fetch address.
  logic [63:0] m_q[$];
  logic [31:0] m_fpc;
  logic        m_mis;
  bit          m_known = 0;

  always @(negedge clk) begin
    bit          e_valid;
    bit          pop_now;
    bit          push_now;
    e_valid = (m_q.size() != 0) && !redirect_valid;
    if (m_known) begin
      chk("model_valid", {31'h0, instr_valid}, {31'h0, e_valid});
      chk("model_data", instr_data, e_valid ? m_q[0][31:0] : NOP);
      chk("model_pc", instr_pc, e_valid ? m_q[0][63:32] : 32'h0);
      chk("model_count", {29'h0, q_count}, 32'(m_q.size()));
      chk("model_rom_addr", rom_addr, m_fpc);
      chk("model_misalign", {31'h0, misalign_err}, {31'h0, m_mis});
    end
    if (reset) begin
      m_q.delete();
      m_fpc   = RESET_PC;
      m_mis   = 1'b0;
      m_known = 1;
    end else if (m_known) begin
      if (redirect_valid) begin
        m_q.delete();
        m_fpc = redirect_pc & 32'hFFFF_FFFC;
        m_mis = (redirect_pc[1:0] != 2'b00);
      end else begin
        m_mis    = 1'b0;
        pop_now  = e_valid && instr_ready;
        push_now = fetch_en && ((m_q.size() < DEPTH) || pop_now);
        if (pop_now) void'(m_q.pop_front());
        if (push_now) begin
          m_q.push_back({m_fpc, rom_f(m_fpc)});
          m_fpc = m_fpc + 32'd4;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect_valid = 1'b0; fetch_en = 1'b0; instr_ready = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; fetch_en = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    cyc(); cyc();
    settle();
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_data", instr_data, NOP);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_count", {29'h0, q_count}, 32'h0);
    chk("rst_rom_addr", rom_addr, RESET_PC);
    chk("rst_misalign", {31'h0, misalign_err}, 32'h0);

    // Streaming from reset
    cyc(); reset = 1'b0; fetch_en = 1'b1; instr_ready = 1'b1;
    settle(); chk("t1_first_valid", {31'h0, instr_valid}, 32'h0);
    cyc(); settle();
    chk("t1_valid", {31'h0, instr_valid}, 32'h1);
    chk("t1_pc0", instr_pc, 32'h0);
    chk("t1_data0", instr_data, 32'h0020_8233);
    for (int i = 1; i < 4; i++) begin
      cyc(); settle(); chk("t1_pc_seq", instr_pc, 32'(4 * i));
    end

    // Backpressure fills the queue, then drains in order
    cyc(); do_reset(); fetch_en = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    settle();
    chk("t2_full_count", {29'h0, q_count}, 32'h4);
    chk("t2_rom_hold", rom_addr, 32'h10);
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle(); chk("t2_drain_pc", instr_pc, 32'(4 * i));
      chk("t2_drain_valid", {31'h0, instr_valid}, 32'h1);
      cyc();
    end

    // Redirect with three entries queued
    do_reset(); fetch_en = 1'b1;
    cyc(); cyc(); cyc();
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    settle();
    chk("t3_count_before", {29'h0, q_count}, 32'h3);
    chk("t3_valid_in_redirect", {31'h0, instr_valid}, 32'h0);
    cyc(); redirect_valid = 1'b0;
    settle();
    chk("t3_count_after", {29'h0, q_count}, 32'h0);
    chk("t3_rom_addr", rom_addr, 32'h40);
    cyc(); settle();
    chk("t3_head_pc", instr_pc, 32'h40);
    chk("t3_head_data", instr_data, rom_f(32'h40));

    // Misaligned redirect
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h42;
    cyc(); redirect_valid = 1'b0;
    settle();
    chk("t4_rom_addr", rom_addr, 32'h40);
    chk("t4_misalign_on", {31'h0, misalign_err}, 32'h1);
    cyc(); settle();
    chk("t4_misalign_off", {31'h0, misalign_err}, 32'h0);

    // fetch_en=0 drains a full queue
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    fetch_en = 1'b0; instr_ready = 1'b1;
    settle(); chk("t5_full", {29'h0, q_count}, 32'h4);
    for (int i = 0; i < 4; i++) begin
      settle(); chk("t5_drain_pc", instr_pc, 32'h40 + 32'(4 * i));
      cyc();
    end
    settle();
    chk("t5_empty_valid", {31'h0, instr_valid}, 32'h0);
    chk("t5_empty_data", instr_data, NOP);
    chk("t5_empty_pc", instr_pc, 32'h0);
    chk("t5_rom_hold", rom_addr, 32'h50);
    cyc(); fetch_en = 1'b1;
    cyc(); settle();
    chk("t5_resume_pc", instr_pc, 32'h50);

    // Reset with full queue and concurrent misaligned redirect
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h83;
    cyc(); reset = 1'b0; redirect_valid = 1'b0; fetch_en = 1'b0;
    settle();
    chk("t6_count", {29'h0, q_count}, 32'h0);
    chk("t6_valid", {31'h0, instr_valid}, 32'h0);
    chk("t6_rom_addr", rom_addr, RESET_PC);
    chk("t6_misalign", {31'h0, misalign_err}, 32'h0);

    // Fetch PC wraps past the top of the address space
    cyc(); fetch_en = 1'b1; instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    cyc(); redirect_valid = 1'b0;
    cyc(); settle(); chk("t7_pc_a", instr_pc, 32'hFFFF_FFF8);
    cyc(); settle(); chk("t7_pc_b", instr_pc, 32'hFFFF_FFFC);
    cyc(); settle(); chk("t7_pc_wrap", instr_pc, 32'h0);
    chk("t7_data_wrap", instr_data, 32'h0020_8233);

    cyc(); cyc(); cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Instruction fetch sequencer between the combinational instruction ROM and the decode stage.
- Owns the fetch PC and drives the ROM address.
- Captures each returned word with its PC into a small in-order queue and presents entries to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue and restarting fetch at the target.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- DEPTH, 4, queue entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- fetch_en  in  1  allow new fetches (0 = hold fetch PC, queue still drains)
- rom_addr  out  32  byte address to ROM; ROM returns rom_data in the same cycle
- rom_data  in  32  instruction word for rom_addr
- redirect_valid  in  1  one-cycle flush-and-jump request from execute
- redirect_pc  in  32  jump/branch target byte address
- instr_valid  out  1  queue head valid toward decode
- instr_ready  in  1  decode accepts head
- instr_data  out  32  head instruction; NOP 32'h0000_0013 when instr_valid=0
- instr_pc  out  32  head PC; 0 when instr_valid=0
- q_count  out  $clog2(DEPTH+1)  current queue occupancy
- misalign_err  out  1  registered one-cycle pulse on a misaligned redirect

Behaviour:
- Reset: fpc=RESET_PC, rd/wr pointers=0, count=0, misalign_err=0. Resulting outputs: instr_valid=0, instr_data=NOP, instr_pc=0, q_count=0, rom_addr=RESET_PC.
- rom_addr = fpc, driven directly from the register with no combinational input path.
- pop = instr_valid & instr_ready.
- push = fetch_en & !redirect_valid & ((count<DEPTH) | pop).
- On push: write {fpc, rom_data} at wr_ptr; wr_ptr+1 mod DEPTH; fpc <= fpc+4.
- fpc wraps 32'hFFFF_FFFC -> 0.
- Latency: a word fetched in cycle N becomes the head earliest in cycle N+1. There is no bypass.
- Sustained throughput is 1 instruction/cycle when fetch_en=1 and instr_ready=1.
- Full with simultaneous pop: push is still allowed and count stays at DEPTH.
- Empty: instr_valid=0; instr_ready is ignored.
- count updates: +1 on push only, -1 on pop only, unchanged on both or neither. Pointers wrap modulo DEPTH.
- Redirect has priority over everything:
  - instr_valid is forced 0 in the redirect cycle, so no pop occurs.
  - No push occurs in the redirect cycle.
  - Next cycle: count=0, both pointers=0, fpc = {redirect_pc[31:2], 2'b00}.
  - The first post-redirect instruction is visible 2 cycles after the redirect cycle.
- Misaligned redirect: if redirect_valid & |redirect_pc[1:0], set misalign_err=1 for exactly the next cycle; the target is still aligned down.
- instr_valid = (count!=0) & !redirect_valid. This combinational path from redirect_valid is intentional.
- Reset asserted mid-operation: discards all queued entries and any concurrent redirect. State next cycle equals the reset state.
- fetch_en=0: fpc holds and the queue drains normally.
- The block does not range-check addresses against ROM size.

Decomposition:
- Package if_pkg:
  - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}
  - localparam INSTR_BYTES=4
  - localparam NOP_INSTR=32'h0000_0013
- Sub-module fetch_fifo:
  - Parameterized on DEPTH; stores fetch_entry_t.
  - Ports: push, pop, flush, head, count.
  - Flush resets the pointers synchronously.
- instr_fetch_ctrl contains the PC register, redirect/misalign logic and the fetch_fifo instance.

Test Plan:
1. Reset, then fetch_en=1, instr_ready=1, ROM[0]=32'h0020_8233 -> first cycle after reset: instr_valid=0. Next cycle: instr_valid=1, instr_pc=0, instr_data=32'h0020_8233. Then PCs 4, 8, C on consecutive cycles.
2. instr_ready=0 for 10 cycles -> q_count saturates at 4 and rom_addr holds 0x10. Releasing instr_ready delivers PCs 0, 4, 8, C in order, then 0x10, with no gaps or duplicates.
3. Redirect to 0x40 while q_count=3 -> instr_valid=0 in the redirect cycle. Next cycle: q_count=0, rom_addr=0x40. Following cycle: head instr_pc=0x40; no stale PC is ever presented.
4. Redirect to 0x42 -> rom_addr=0x40 next cycle and misalign_err high for exactly that one cycle.
5. fetch_en=0 with a full queue and instr_ready=1 -> 4 pops, then instr_valid=0 with NOP and pc 0; rom_addr unchanged. Restoring fetch_en resumes at the held PC.
6. Reset asserted with full queue and concurrent redirect -> next cycle: q_count=0, instr_valid=0, rom_addr=RESET_PC, misalign_err=0.
